shot_controller: RTL and testbench
==================================

// Module: shot_controller
// PURPOSE
//  Initiator side of the shot/score interface: conditions the fire pushbutton, validates the
//  player's shot, and issues it to the scorer over a req/ack handshake. It then registers the
//  returned result for the LEDs and HEX0. It owns game state: big-bomb inventory, shot count,
//  cumulative hits, ships-hit mask and game-over. It sits between the board switches/KEY and the scorer.
// PARAMETERS
//  BIG_BOMBS        2    big bombs at game start (1..2; bigLeft 2'b11 never produced)
//  MAX_SHOTS        30   accepted shots before gameOver
//  HITS_TO_WIN      19   cumulative hit squares that end the game
//  DEBOUNCE_CYCLES  16   stable cycles required on fire (only with FIRE_DEBOUNCE_EN)
// PORTS
//  clock        in   1  system clock
//  reset        in   1  synchronous, active-high
//  X, Y         in   4  shot column/row from switches, valid range 1..10
//  big          in   1  request big (3x3) bomb
//  fire_n       in   1  raw pushbutton, active-low, asynchronous to clock
//  scoreReq     out  1  shot valid to scorer
//  shotX, shotY out  4  latched coordinates, stable while scoreReq
//  shotBig      out  1  latched big flag, stable while scoreReq
//  scoreAck     in   1  scorer result valid this cycle
//  isHit, isNearMiss, isMiss  in  1  scorer result flags (sampled on ack)
//  numHit       in   4  squares hit by this shot, 0..9
//  biggestShip  in   5  one-hot largest ship hit, 0 = none
//  hitLed, nearLed, missLed  out 1  registered result of last scored shot
//  lastNumHit   out  4  registered numHit of last shot (to HEX0)
//  shipsHitMask out  5  OR of every biggestShip received this game
//  bigLeft      out  2  big bombs remaining
//  shotsFired   out  7  accepted shots this game
//  totalHits    out  7  cumulative hit squares, saturates at 127
//  wrong        out  1  last fire attempt rejected (drives HEX6/HEX7)
//  gameOver     out  1  no further shots accepted
// BEHAVIOUR
//  Reset: all outputs 0 except bigLeft=BIG_BOMBS; FSM->IDLE; scoreReq drops in the reset cycle.
//  fire_n: 2-flop synchronizer, then one-cycle pulse on the falling edge (press). Holding gives one pulse.
//  FSM IDLE -> (fire pulse & !gameOver) CHECK; fire pulses outside IDLE are ignored.
//  CHECK (1 cycle): invalid if X or Y outside 1..10, or big & bigLeft==0.
//   Invalid: wrong<=1, shot not counted, back to IDLE. Valid: wrong<=0, latch X/Y/big, go to REQ.
//  REQ: scoreReq=1, shot* stable; leave when scoreAck=1 sampled high. The transfer completes in that same cycle.
//   Result inputs are sampled only in the ack cycle. scoreAck outside REQ is ignored.
//  UPDATE (1 cycle): register LEDs/lastNumHit, shipsHitMask|=biggestShip, shotsFired+=1,
//   totalHits+=numHit (saturating), bigLeft-=shotBig; then gameOver<=1 if
//   shotsFired==MAX_SHOTS or totalHits>=HITS_TO_WIN (using the updated values); -> IDLE.
//  Latency: fire press to scoreReq = sync(2)+edge(1)+CHECK(1) = 4 cycles; ack to new outputs = 1.
//  gameOver sticky until reset; fire is then ignored and wrong is unchanged.
//  Fire press arriving during REQ/UPDATE: dropped, not queued.
//  Reset mid-REQ: transaction abandoned; the scorer must tolerate req withdrawal.
// CONFIGURATION
//  FIRE_DEBOUNCE_EN defined: synced fire must be stable DEBOUNCE_CYCLES before its edge is
//   accepted; latency +DEBOUNCE_CYCLES. Undefined: sync + edge detect only; glitches pass through.
// STRUCTURE
//  battleship_pkg: coord_t (logic[3:0]), ship_mask_t (logic[4:0]), GRID_MIN=1, GRID_MAX=10,
//   shot_state_t enum {IDLE,CHECK,REQ,UPDATE}.
//  Sub-module fire_conditioner: synchronizer + optional debounce + falling-edge pulse.
// TESTING
//  1 reset; press at X=7,Y=6,big=0; ack with isHit=1, numHit=1, ship=5'b00001 -> hitLed=1, shotsFired=1, totalHits=1.
//  2 X=0 or Y=11, press -> wrong=1, no scoreReq, shotsFired unchanged; valid press next -> wrong=0.
//  3 big=1 three times with BIG_BOMBS=2 -> bigLeft 2,1,0; third press -> wrong=1, no req.
//  4 hold scoreAck low 50 cycles in REQ -> scoreReq, shotX/Y/Big stable; extra presses ignored.
//  5 MAX_SHOTS misses -> gameOver=1 after the last ack; next press -> no req.
//  6 assert reset during REQ -> scoreReq=0 next cycle; all counters cleared; bigLeft=2.

Source files
------------

// File: rtl/battleship_pkg.sv
// ---------------------------------------------------------------------------
// battleship_pkg
// Shared types and constants for the shot/score side of the battleship game.
// Items:
//   coord_t       4-bit grid coordinate (column or row)
//   ship_mask_t   one bit per ship, used for biggestShip and shipsHitMask
//   GRID_MIN/MAX  legal coordinate range, inclusive
//   shot_state_t  states of the shot controller FSM
//   coordValid    true when a coordinate lies on the board
// ---------------------------------------------------------------------------
package battleship_pkg;

    typedef logic [3:0] coord_t;
    typedef logic [4:0] ship_mask_t;

    localparam coord_t GRID_MIN = 4'd1;
    localparam coord_t GRID_MAX = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        REQ,
        UPDATE
    } shot_state_t;

    // A coordinate is usable only when it lands on the 10x10 board.
    function automatic logic coordValid(input coord_t c);
        return (c >= GRID_MIN) && (c <= GRID_MAX);
    endfunction

endpackage

// File: rtl/shot_controller_if.sv
// ---------------------------------------------------------------------------
// shot_controller_if
// Shot/score handshake between the shot controller (master) and the scorer
// (slave).
// Signals:
//   scoreReq      master->slave  shot valid, held until scoreAck
//   shotX, shotY  master->slave  latched coordinates, stable while scoreReq
//   shotBig       master->slave  latched big-bomb flag, stable while scoreReq
//   scoreAck      slave->master  result valid this cycle
//   isHit, isNearMiss, isMiss    slave->master result flags
//   numHit        slave->master  squares hit by the shot, 0..9
//   biggestShip   slave->master  one-hot largest ship hit, 0 = none
// ---------------------------------------------------------------------------
interface shot_controller_if;
    import battleship_pkg::*;

    logic       scoreReq;
    coord_t     shotX;
    coord_t     shotY;
    logic       shotBig;
    logic       scoreAck;
    logic       isHit;
    logic       isNearMiss;
    logic       isMiss;
    logic [3:0] numHit;
    ship_mask_t biggestShip;

    modport master (
        output scoreReq, shotX, shotY, shotBig,
        input  scoreAck, isHit, isNearMiss, isMiss, numHit, biggestShip
    );

    modport slave (
        input  scoreReq, shotX, shotY, shotBig,
        output scoreAck, isHit, isNearMiss, isMiss, numHit, biggestShip
    );

endinterface

// File: rtl/shot_controller_fire_conditioner.sv
// ---------------------------------------------------------------------------
// fire_conditioner
// Turns the raw active-low fire pushbutton into a single-cycle press pulse.
// Ports:
//   clock      in  system clock
//   reset      in  synchronous, active-high
//   fire_n     in  raw pushbutton, active-low, asynchronous to clock
//   firePulse  out one-cycle pulse on each press (falling edge of fire_n)
// Configuration:
//   FIRE_DEBOUNCE_EN  when defined, the synchronized level must hold for
//                     DEBOUNCE_CYCLES cycles before it is believed.
// ---------------------------------------------------------------------------
module fire_conditioner
`ifdef FIRE_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
    input  logic clock,
    input  logic reset,
    input  logic fire_n,
    output logic firePulse
);

    logic syncStage1;
    logic syncStage2;
    logic conditioned;
    logic prevLevel;

    // Two-flop synchronizer; the button idles high so reset to 1 to avoid
    // a phantom press coming out of reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            syncStage1 <= 1'b1;
            syncStage2 <= 1'b1;
        end else begin
            syncStage1 <= fire_n;
            syncStage2 <= syncStage1;
        end
    end

`ifdef FIRE_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             stableLevel;
    logic [CNT_W-1:0] stableCount;

    // The accepted level only moves after the synchronized input has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            stableLevel <= 1'b1;
            stableCount <= '0;
        end else if (syncStage2 == stableLevel) begin
            stableCount <= '0;
        end else if (stableCount == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stableLevel <= syncStage2;
            stableCount <= '0;
        end else begin
            stableCount <= stableCount + 1'b1;
        end
    end

    assign conditioned = stableLevel;
`else
    assign conditioned = syncStage2;
`endif

    // Remember the previous conditioned level for edge detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            prevLevel <= 1'b1;
        end else begin
            prevLevel <= conditioned;
        end
    end

    // The pulse is combinational off registered levels so the FSM sees the
    // press in the same cycle the synchronizer delivers it.
    assign firePulse = prevLevel & ~conditioned;

endmodule

// File: rtl/shot_controller.sv
// ---------------------------------------------------------------------------
// shot_controller
// Initiator side of the shot/score interface: conditions the fire button,
// validates the player's shot, issues it to the scorer over req/ack, and
// keeps the game state (big bombs, shot count, hits, ship mask, game over).
// Ports:
//   clock, reset         system clock, synchronous active-high reset
//   X, Y                 shot column/row from switches, legal 1..10
//   big                  request a big (3x3) bomb
//   fire_n               raw active-low pushbutton
//   score                master side of shot_controller_if
//   hitLed/nearLed/missLed, lastNumHit  result of the last scored shot
//   shipsHitMask         OR of every biggestShip seen this game
//   bigLeft              big bombs remaining
//   shotsFired           accepted shots this game
//   totalHits            cumulative hit squares, saturating at 127
//   wrong                last fire attempt was rejected
//   gameOver             no further shots accepted until reset
// Configuration:
//   FIRE_DEBOUNCE_EN  enables the fire debounce filter in fire_conditioner.
// ---------------------------------------------------------------------------
module shot_controller
    import battleship_pkg::*;
#(
    parameter int BIG_BOMBS       = 2,
    parameter int MAX_SHOTS       = 30,
    parameter int HITS_TO_WIN     = 19,
    parameter int DEBOUNCE_CYCLES = 16
)(
    input  logic               clock,
    input  logic               reset,
    input  coord_t             X,
    input  coord_t             Y,
    input  logic               big,
    input  logic               fire_n,
    shot_controller_if.master  score,
    output logic               hitLed,
    output logic               nearLed,
    output logic               missLed,
    output logic [3:0]         lastNumHit,
    output ship_mask_t         shipsHitMask,
    output logic [1:0]         bigLeft,
    output logic [6:0]         shotsFired,
    output logic [6:0]         totalHits,
    output logic               wrong,
    output logic               gameOver
);

    shot_state_t state;
    logic        firePulse;
    logic [6:0]  nextShots;
    logic [7:0]  hitSum;
    logic [6:0]  nextHits;

`ifdef FIRE_DEBOUNCE_EN
    fire_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_fire (
        .clock     (clock),
        .reset     (reset),
        .fire_n    (fire_n),
        .firePulse (firePulse)
    );
`else
    fire_conditioner u_fire (
        .clock     (clock),
        .reset     (reset),
        .fire_n    (fire_n),
        .firePulse (firePulse)
    );
`endif

    // Post-shot counter values; gameOver is decided on these so the final
    // shot ends the game in the same cycle its result lands.
    always_comb begin
        nextShots = shotsFired + 7'd1;
        hitSum    = {1'b0, totalHits} + {4'd0, score.numHit};
        nextHits  = hitSum[7] ? 7'd127 : hitSum[6:0];
    end

    // Shot FSM. Every output is registered here. The scorer result is taken
    // on the ack edge itself, so the LEDs and counters move one cycle after
    // the ack; UPDATE is a one-cycle settle that drops any fire press.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            score.scoreReq <= 1'b0;
            score.shotX    <= '0;
            score.shotY    <= '0;
            score.shotBig  <= 1'b0;
            hitLed         <= 1'b0;
            nearLed        <= 1'b0;
            missLed        <= 1'b0;
            lastNumHit     <= '0;
            shipsHitMask   <= '0;
            bigLeft        <= 2'(BIG_BOMBS);
            shotsFired     <= '0;
            totalHits      <= '0;
            wrong          <= 1'b0;
            gameOver       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (firePulse && !gameOver) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (!coordValid(X) || !coordValid(Y) || (big && bigLeft == 2'd0)) begin
                        wrong <= 1'b1;
                        state <= IDLE;
                    end else begin
                        wrong          <= 1'b0;
                        score.shotX    <= X;
                        score.shotY    <= Y;
                        score.shotBig  <= big;
                        score.scoreReq <= 1'b1;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (score.scoreAck) begin
                        score.scoreReq <= 1'b0;
                        hitLed         <= score.isHit;
                        nearLed        <= score.isNearMiss;
                        missLed        <= score.isMiss;
                        lastNumHit     <= score.numHit;
                        shipsHitMask   <= shipsHitMask | score.biggestShip;
                        shotsFired     <= nextShots;
                        totalHits      <= nextHits;
                        bigLeft        <= bigLeft - {1'b0, score.shotBig};
                        gameOver       <= (nextShots == 7'(MAX_SHOTS)) ||
                                          (nextHits >= 7'(HITS_TO_WIN));
                        state          <= UPDATE;
                    end
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shot_controller.sv
// ---------------------------------------------------------------------------
// tb_shot_controller
// Directed bench for shot_controller. A game-level model (shot count, hit
// total, bombs left, last result) tracks what the outputs must show and is
// compared against the DUT on every falling clock edge; a few literal
// expectations pin the model to known game situations.
// ---------------------------------------------------------------------------
module tb_shot_controller;
    import battleship_pkg::*;

    localparam int MAX_SHOTS   = 30;
    localparam int HITS_TO_WIN = 19;

    logic       clock = 1'b0;
    logic       reset;
    coord_t     X;
    coord_t     Y;
    logic       big;
    logic       fire_n;
    logic       hitLed, nearLed, missLed;
    logic [3:0] lastNumHit;
    ship_mask_t shipsHitMask;
    logic [1:0] bigLeft;
    logic [6:0] shotsFired;
    logic [6:0] totalHits;
    logic       wrong;
    logic       gameOver;

    shot_controller_if sif();

    shot_controller #(
        .BIG_BOMBS(2), .MAX_SHOTS(MAX_SHOTS), .HITS_TO_WIN(HITS_TO_WIN), .DEBOUNCE_CYCLES(16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .X            (X),
        .Y            (Y),
        .big          (big),
        .fire_n       (fire_n),
        .score        (sif),
        .hitLed       (hitLed),
        .nearLed      (nearLed),
        .missLed      (missLed),
        .lastNumHit   (lastNumHit),
        .shipsHitMask (shipsHitMask),
        .bigLeft      (bigLeft),
        .shotsFired   (shotsFired),
        .totalHits    (totalHits),
        .wrong        (wrong),
        .gameOver     (gameOver)
    );

    always #5 clock = ~clock;

    int nChecks = 0;
    int nPass   = 0;
    bit checkEn = 1'b0;

    // Game model
    bit       mReq, mShotBig, mHit, mNear, mMiss, mWrong, mOver;
    int       mShotX, mShotY, mNum, mMask, mBig, mShots, mTotal;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        else nPass++;
    endtask

    task automatic modelReset();
        mReq = 0; mShotX = 0; mShotY = 0; mShotBig = 0;
        mHit = 0; mNear = 0; mMiss = 0; mNum = 0; mMask = 0;
        mBig = 2; mShots = 0; mTotal = 0; mWrong = 0; mOver = 0;
    endtask

    // Compare every settled output against the model once per cycle.
    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput("scoreReq", 32'(sif.scoreReq), 32'(mReq));
            if (mReq) begin
                checkOutput("shotX", 32'(sif.shotX), 32'(mShotX));
                checkOutput("shotY", 32'(sif.shotY), 32'(mShotY));
                checkOutput("shotBig", 32'(sif.shotBig), 32'(mShotBig));
            end
            checkOutput("hitLed", 32'(hitLed), 32'(mHit));
            checkOutput("nearLed", 32'(nearLed), 32'(mNear));
            checkOutput("missLed", 32'(missLed), 32'(mMiss));
            checkOutput("lastNumHit", 32'(lastNumHit), 32'(mNum));
            checkOutput("shipsHitMask", 32'(shipsHitMask), 32'(mMask));
            checkOutput("bigLeft", 32'(bigLeft), 32'(mBig));
            checkOutput("shotsFired", 32'(shotsFired), 32'(mShots));
            checkOutput("totalHits", 32'(totalHits), 32'(mTotal));
            checkOutput("wrong", 32'(wrong), 32'(mWrong));
            checkOutput("gameOver", 32'(gameOver), 32'(mOver));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic resetDut();
        reset = 1'b1;
        @(posedge clock);
        #1;
        modelReset();
        checkOutput("rst_scoreReq", 32'(sif.scoreReq), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Press fire with the given shot; the press reaches CHECK on the third
    // edge and scoreReq (or wrong) appears on the fourth.
    task automatic applyStimulus(input coord_t x, input coord_t y, input logic b);
        bit valid;
        X = x; Y = y; big = b;
        fire_n = 1'b0;
        idle(3);
        checkOutput("lat3_scoreReq", 32'(sif.scoreReq), 32'd0);
        idle(1);
        valid = (x >= 1 && x <= 10 && y >= 1 && y <= 10 && !(b && mBig == 0));
        if (!mOver) begin
            mWrong = !valid;
            if (valid) begin
                mReq = 1; mShotX = x; mShotY = y; mShotBig = b;
            end
        end
        checkOutput("lat4_scoreReq", 32'(sif.scoreReq), 32'(mReq));
        fire_n = 1'b1;
    endtask

    // Scorer answers in the current cycle; results are garbage otherwise.
    task automatic giveAck(input bit h, input bit n, input bit m, input int num, input int ship);
        sif.scoreAck = 1'b1;
        sif.isHit = h; sif.isNearMiss = n; sif.isMiss = m;
        sif.numHit = 4'(num); sif.biggestShip = 5'(ship);
        idle(1);
        sif.scoreAck = 1'b0;
        sif.isHit = 1'b1; sif.isNearMiss = 1'b1; sif.isMiss = 1'b1;
        sif.numHit = 4'd9; sif.biggestShip = 5'b11111;
        mReq = 0;
        mHit = h; mNear = n; mMiss = m; mNum = num;
        mMask = mMask | ship;
        mShots = mShots + 1;
        mTotal = (mTotal + num > 127) ? 127 : mTotal + num;
        mBig = mBig - (mShotBig ? 1 : 0);
        mOver = (mShots == MAX_SHOTS) || (mTotal >= HITS_TO_WIN);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset = 1'b1; fire_n = 1'b1; X = 4'd1; Y = 4'd1; big = 1'b0;
        sif.scoreAck = 1'b0; sif.isHit = 1'b0; sif.isNearMiss = 1'b0;
        sif.isMiss = 1'b0; sif.numHit = 4'd0; sif.biggestShip = 5'd0;
        idle(2);
        reset = 1'b0;
        modelReset();
        checkOutput("reset_bigLeft", 32'(bigLeft), 32'd2);
        checkOutput("reset_shotsFired", 32'(shotsFired), 32'd0);
        checkEn = 1'b1;

        // Scenario 1: single hit on ship 0
        applyStimulus(4'd7, 4'd6, 1'b0);
        checkOutput("s1_shotX", 32'(sif.shotX), 32'd7);
        giveAck(1, 0, 0, 1, 5'b00001);
        checkOutput("s1_hitLed", 32'(hitLed), 32'd1);
        checkOutput("s1_shotsFired", 32'(shotsFired), 32'd1);
        checkOutput("s1_totalHits", 32'(totalHits), 32'd1);
        idle(3);

        // Stray ack while idle must be ignored
        sif.scoreAck = 1'b1;
        idle(1);
        sif.scoreAck = 1'b0;
        idle(2);

        // Scenario 2: off-board coordinates then a good shot
        applyStimulus(4'd0, 4'd5, 1'b0);
        checkOutput("s2_wrong_x0", 32'(wrong), 32'd1);
        idle(3);
        applyStimulus(4'd5, 4'd11, 1'b0);
        checkOutput("s2_shots_unchanged", 32'(shotsFired), 32'd1);
        idle(3);
        applyStimulus(4'd10, 4'd10, 1'b0);
        checkOutput("s2_wrong_cleared", 32'(wrong), 32'd0);
        giveAck(0, 1, 0, 0, 0);
        idle(3);

        // Scenario 3: big bombs run out
        applyStimulus(4'd2, 4'd2, 1'b1);
        giveAck(1, 0, 0, 3, 5'b00100);
        checkOutput("s3_bigLeft1", 32'(bigLeft), 32'd1);
        idle(3);
        applyStimulus(4'd4, 4'd4, 1'b1);
        giveAck(0, 0, 1, 0, 0);
        checkOutput("s3_bigLeft0", 32'(bigLeft), 32'd0);
        idle(3);
        applyStimulus(4'd5, 4'd5, 1'b1);
        checkOutput("s3_wrong", 32'(wrong), 32'd1);
        idle(3);

        // Scenario 4: long wait in REQ with inputs moving and extra presses
        applyStimulus(4'd3, 4'd9, 1'b0);
        X = 4'd8; Y = 4'd1; big = 1'b1;
        idle(20);
        fire_n = 1'b0;
        idle(5);
        fire_n = 1'b1;
        idle(25);
        checkOutput("s4_shotY_held", 32'(sif.shotY), 32'd9);
        giveAck(1, 0, 0, 2, 5'b10000);
        checkOutput("s4_mask", 32'(shipsHitMask), 32'b10101);
        idle(3);

        // Scenario 6: reset while a request is outstanding
        applyStimulus(4'd6, 4'd6, 1'b0);
        idle(2);
        resetDut();
        checkOutput("s6_bigLeft", 32'(bigLeft), 32'd2);
        checkOutput("s6_totalHits", 32'(totalHits), 32'd0);
        idle(3);

        // Scenario 5: a full game of misses
        for (int i = 0; i < MAX_SHOTS; i++) begin
            applyStimulus(4'(1 + (i % 10)), 4'd3, 1'b0);
            giveAck(0, 0, 1, 0, 0);
            idle(3);
        end
        checkOutput("s5_gameOver", 32'(gameOver), 32'd1);
        checkOutput("s5_shotsFired", 32'(shotsFired), 32'd30);
        applyStimulus(4'd0, 4'd0, 1'b0);
        checkOutput("s5_wrong_kept", 32'(wrong), 32'd0);
        idle(3);

        // Win by hit count: 9 + 9 stays in play, one more ends it
        resetDut();
        applyStimulus(4'd5, 4'd5, 1'b1);
        giveAck(1, 0, 0, 9, 5'b01000);
        idle(3);
        applyStimulus(4'd8, 4'd8, 1'b1);
        giveAck(1, 0, 0, 9, 5'b00010);
        checkOutput("win_not_yet", 32'(gameOver), 32'd0);
        idle(3);
        applyStimulus(4'd1, 4'd10, 1'b0);
        giveAck(1, 0, 0, 1, 5'b00001);
        checkOutput("win_gameOver", 32'(gameOver), 32'd1);
        checkOutput("win_totalHits", 32'(totalHits), 32'd19);
        idle(3);

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
